active_list_ctrl: RTL and testbench

Pointer and occupancy controller for the active list (reorder buffer). Allocates tail entries for each dispatch group and drives the active-list data RAM write ports: one address and write enable per dispatch lane. Drives the RAM read addresses from the head for commit and retires committed entries. Produces the dispatch stall signal, and resets all pointers on a pipeline flush.

---
 rtl/al_pkg.sv | 21 ++
 rtl/active_list_ctrl.sv | 80 ++++++++
 tb/tb_active_list_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/al_pkg.sv
// Shared constants and pointer arithmetic for the active-list controller.
package al_pkg;

    localparam int unsigned AL_DEPTH          = 16;
    localparam int unsigned AL_INDEX          = $clog2(AL_DEPTH);
    localparam int unsigned AL_DISPATCH_WIDTH = 4;
    localparam int unsigned AL_COMMIT_WIDTH   = 4;
    localparam int unsigned AL_DCNT_W         = $clog2(AL_DISPATCH_WIDTH + 1);
    localparam int unsigned AL_CCNT_W         = $clog2(AL_COMMIT_WIDTH + 1);

    // DEPTH is a power of two, so wrapping is just truncation of the sum.
    function automatic logic [AL_INDEX-1:0] al_wrap_add(
        input logic [AL_INDEX-1:0] ptr,
        input logic [AL_INDEX:0]   inc
    );
        logic [AL_INDEX:0] sum;
        sum = {1'b0, ptr} + inc;
        return sum[AL_INDEX-1:0];
    endfunction

endpackage

// File: rtl/active_list_ctrl.sv
// Active-list (ROB) pointer/occupancy controller: allocates tail entries per
// dispatch group, exposes head entries for commit, and generates dispatch stall.
module active_list_ctrl
    import al_pkg::*;
#(
    parameter int unsigned DEPTH          = AL_DEPTH,
    parameter int unsigned INDEX          = AL_INDEX,
    parameter int unsigned DISPATCH_WIDTH = AL_DISPATCH_WIDTH,
    parameter int unsigned COMMIT_WIDTH   = AL_COMMIT_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       flush_i,
    input  logic                                       dispatchReady_i,
    input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]        dispatchCount_i,
    input  logic [$clog2(COMMIT_WIDTH+1)-1:0]          commitCount_i,
    output logic [DISPATCH_WIDTH-1:0][INDEX-1:0]       wrAddr_o,
    output logic [DISPATCH_WIDTH-1:0]                  we_o,
    output logic [COMMIT_WIDTH-1:0][INDEX-1:0]         rdAddr_o,
    output logic [COMMIT_WIDTH-1:0]                    headValid_o,
    output logic                                       alStall_o,
    output logic [INDEX-1:0]                           alHead_o,
    output logic [INDEX-1:0]                           alTail_o,
    output logic [INDEX:0]                             alCount_o
);

    localparam logic [INDEX:0] DW_L      = (INDEX+1)'(DISPATCH_WIDTH);
    localparam logic [INDEX:0] CW_L      = (INDEX+1)'(COMMIT_WIDTH);
    // Stall when free entries (DEPTH - count) drop below one full group.
    localparam logic [INDEX:0] STALL_THR = (INDEX+1)'(DEPTH - DISPATCH_WIDTH);

    logic [INDEX-1:0] r_head;
    logic [INDEX-1:0] r_tail;
    logic [INDEX:0]   r_count;

    logic             w_stall;
    logic             w_accept;
    logic [INDEX:0]   w_dcnt;
    logic [INDEX:0]   w_ccnt;
    logic [INDEX:0]   w_d;
    logic [INDEX:0]   w_c_lim;
    logic [INDEX:0]   w_c;

    assign w_stall  = (r_count > STALL_THR);
    assign w_accept = dispatchReady_i && !w_stall && !flush_i && !reset;

    assign w_dcnt   = (INDEX+1)'(dispatchCount_i);
    assign w_ccnt   = (INDEX+1)'(commitCount_i);
    assign w_d      = w_accept ? ((w_dcnt > DW_L) ? DW_L : w_dcnt) : '0;
    assign w_c_lim  = (w_ccnt > r_count) ? r_count : w_ccnt;
    assign w_c      = (flush_i || reset) ? '0 : ((w_c_lim > CW_L) ? CW_L : w_c_lim);

    for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_wr_lane
        assign wrAddr_o[i] = al_wrap_add(r_tail, (INDEX+1)'(i));
        assign we_o[i]     = (w_d > (INDEX+1)'(i));
    end

    for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_rd_lane
        assign rdAddr_o[i]    = al_wrap_add(r_head, (INDEX+1)'(i));
        assign headValid_o[i] = (r_count > (INDEX+1)'(i));
    end

    assign alStall_o = w_stall;
    assign alHead_o  = r_head;
    assign alTail_o  = r_tail;
    assign alCount_o = r_count;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= al_wrap_add(r_head, w_c);
            r_tail  <= al_wrap_add(r_tail, w_d);
            r_count <= r_count + w_d - w_c;
        end
    end

endmodule

// File: tb/tb_active_list_ctrl.sv
// Randomized + directed bench for active_list_ctrl against an integer occupancy model.
module tb_active_list_ctrl;

    localparam int DEPTH = 16;
    localparam int DW    = 4;
    localparam int CW    = 4;

    logic               clk;
    logic               reset;
    logic               flush_i;
    logic               dispatchReady_i;
    logic [2:0]         dispatchCount_i;
    logic [2:0]         commitCount_i;
    logic [3:0][3:0]    wrAddr_o;
    logic [3:0]         we_o;
    logic [3:0][3:0]    rdAddr_o;
    logic [3:0]         headValid_o;
    logic               alStall_o;
    logic [3:0]         alHead_o;
    logic [3:0]         alTail_o;
    logic [4:0]         alCount_o;

    active_list_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .dispatchReady_i (dispatchReady_i),
        .dispatchCount_i (dispatchCount_i),
        .commitCount_i   (commitCount_i),
        .wrAddr_o        (wrAddr_o),
        .we_o            (we_o),
        .rdAddr_o        (rdAddr_o),
        .headValid_o     (headValid_o),
        .alStall_o       (alStall_o),
        .alHead_o        (alHead_o),
        .alTail_o        (alTail_o),
        .alCount_o       (alCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: plain integers, list occupancy as a ring.
    int m_head  = 0;
    int m_tail  = 0;
    int m_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit m_stall();
        return (DEPTH - m_count) < DW;
    endfunction

    task automatic check_state();
        logic [15:0] exp_rd;
        logic [3:0]  exp_hv;
        for (int i = 0; i < CW; i++) begin
            exp_rd[i*4 +: 4] = 4'((m_head + i) % DEPTH);
            exp_hv[i]        = (i < m_count);
        end
        check("head",      64'(alHead_o),    64'(m_head));
        check("tail",      64'(alTail_o),    64'(m_tail));
        check("count",     64'(alCount_o),   64'(m_count));
        check("stall",     64'(alStall_o),   64'(m_stall()));
        check("rdaddr",    64'(rdAddr_o),    64'(exp_rd));
        check("headvalid", 64'(headValid_o), 64'(exp_hv));
    endtask

    task automatic drive(input bit rst, input bit fl, input bit rdy, input int dc, input int cc);
        reset           = rst;
        flush_i         = fl;
        dispatchReady_i = rdy;
        dispatchCount_i = 3'(dc);
        commitCount_i   = 3'(cc);
        #1;
    endtask

    // Drive one cycle, check write-side outputs, clock, advance model, check state.
    task automatic step(input bit rst, input bit fl, input bit rdy, input int dc, input int cc);
        int d;
        int c;
        logic [15:0] exp_wr;
        logic [3:0]  exp_we;
        drive(rst, fl, rdy, dc, cc);
        d = (rdy && !m_stall() && !fl && !rst) ? imin(dc, DW) : 0;
        c = (fl || rst) ? 0 : imin(imin(cc, m_count), CW);
        for (int i = 0; i < DW; i++) begin
            exp_wr[i*4 +: 4] = 4'((m_tail + i) % DEPTH);
            exp_we[i]        = (i < d);
        end
        check("we",     64'(we_o),     64'(exp_we));
        check("wraddr", 64'(wrAddr_o), 64'(exp_wr));
        @(posedge clk);
        if (rst || fl) begin
            m_head = 0; m_tail = 0; m_count = 0;
        end else begin
            m_tail  = (m_tail + d) % DEPTH;
            m_head  = (m_head + c) % DEPTH;
            m_count = m_count + d - c;
        end
        #1;
        check_state();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_state();
        check("rst_we", 64'(we_o), 64'(0));
        check("rst_wraddr", 64'(wrAddr_o), 64'(16'h3210));

        // Reset then dispatch
        step(1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b1, 4, 0);
        check("d1_we", 64'(we_o), 64'(4'hF));
        check("d1_wraddr", 64'(wrAddr_o), 64'(16'h3210));
        step(1'b0, 1'b0, 1'b1, 4, 0);
        check("d1_tail", 64'(alTail_o), 64'(4));
        check("d1_hv", 64'(headValid_o), 64'(4'hF));

        // Stall threshold
        step(1'b0, 1'b0, 1'b1, 4, 0);
        step(1'b0, 1'b0, 1'b1, 4, 0);
        step(1'b0, 1'b0, 1'b1, 3, 0);
        check("st_count", 64'(alCount_o), 64'(15));
        check("st_stall", 64'(alStall_o), 64'(1));
        step(1'b0, 1'b0, 1'b1, 2, 0);
        check("st_tail", 64'(alTail_o), 64'(15));

        // Wrap-around: reach head=tail=14 with count 0
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 4, 0);
        step(1'b0, 1'b0, 1'b1, 4, 0);
        step(1'b0, 1'b0, 1'b1, 4, 0);
        step(1'b0, 1'b0, 1'b1, 2, 4);
        step(1'b0, 1'b0, 1'b0, 0, 4);
        step(1'b0, 1'b0, 1'b0, 0, 4);
        step(1'b0, 1'b0, 1'b0, 0, 4);
        check("wr_empty", 64'(alCount_o), 64'(0));
        drive(1'b0, 1'b0, 1'b1, 4, 0);
        check("wr_wraddr", 64'(wrAddr_o), 64'(16'h10FE));
        step(1'b0, 1'b0, 1'b1, 4, 0);
        check("wr_tail", 64'(alTail_o), 64'(2));
        check("wr_rdaddr", 64'(rdAddr_o), 64'(16'h10FE));

        // Simultaneous dispatch and commit at count 5
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 4, 0);
        step(1'b0, 1'b0, 1'b1, 1, 0);
        step(1'b0, 1'b0, 1'b1, 2, 3);
        check("sim_count", 64'(alCount_o), 64'(4));
        check("sim_head", 64'(alHead_o), 64'(3));
        check("sim_tail", 64'(alTail_o), 64'(7));

        // Commit clamp
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 2, 0);
        step(1'b0, 1'b0, 1'b0, 0, 4);
        check("cc_head", 64'(alHead_o), 64'(2));
        check("cc_hv", 64'(headValid_o), 64'(0));

        // Flush over dispatch at count 9
        step(1'b0, 1'b0, 1'b1, 4, 0);
        step(1'b0, 1'b0, 1'b1, 4, 0);
        step(1'b0, 1'b0, 1'b1, 1, 0);
        drive(1'b0, 1'b1, 1'b1, 4, 0);
        check("fl_we", 64'(we_o), 64'(0));
        step(1'b0, 1'b1, 1'b1, 4, 0);
        check("fl_count", 64'(alCount_o), 64'(0));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 99) < 75), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
